// File: rtl/BiSet.sv
// Shared BiSet bus types, widths and pack/unpack helpers used by the arbiter and its clients.
// Latency: none, declarations only.
// Backpressure: none; the bus has no stall, every slave replies one cycle after the ctrl cycle.
package BiSet;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Control beat driven by the arbiter to every slave; all-zero means no access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } biSetCtrl;

  // Slave replies are OR-combined, so an undecoded address reads back as zero.
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } biSetReply;

  // Arbiter sequencer states: one grant cycle, one ctrl cycle, one reply cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  function automatic biSetCtrl BiSetCtrlPack(input logic [ADDR_W-1:0] addr,
                                             input logic              we,
                                             input logic [DATA_W-1:0] data);
    biSetCtrl c;
    c.addr = addr;
    c.we   = we;
    c.data = data;
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] BiSetReplyData(input biSetReply reply);
    return reply.data;
  endfunction

endpackage

// File: rtl/bi_set_rr_pick.sv
// Round-robin picker: first requester at or after last+1 (wrapping) that is requesting and not masked.
// Latency: purely combinational.
// Backpressure: none; vld_o low when no eligible requester exists.
module bi_set_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N_REQ-1:0] eligible;

  assign eligible = req_i & ~mask_i;

  // Walk the candidates in priority order starting just after the last winner; first hit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    vld_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(last_i) + 1 + i) % N_REQ);
      if (!vld_o && eligible[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/bi_set_arbiter.sv
// Round-robin arbiter sharing one BiSet bus among N_REQ requesters with a fixed 3-cycle sequence.
// Latency: req sampled at t, ctrl on bus at t+1, reply captured at t+2, ack/rdata at t+3.
// Backpressure: requesters hold req until their one-cycle ack; one transaction per 3 cycles.
module bi_set_arbiter
  import BiSet::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              we_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]              ack_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          busy_o,
  output biSetCtrl                      setCtrl_o,
  input  biSetReply                     setReply_i
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic              we_q, we_d;
  biSetCtrl          ctrl_q, ctrl_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;

  // The requester being acked this cycle is masked so it cannot win straight back.
  bi_set_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i  (req_i),
    .mask_i (ack_q),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  // Sequencer next-state: grant and latch in IDLE, drive bus in ISSUE, sample reply in CAPTURE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    ctrl_d  = '0;
    ack_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_ISSUE;
          last_d  = pick_idx;
          gnt_d   = pick_idx;
          we_d    = we_i[pick_idx];
          ctrl_d  = BiSetCtrlPack(addr_i[pick_idx], we_i[pick_idx], wdata_i[pick_idx]);
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d        = ST_IDLE;
        ack_d[gnt_q]   = 1'b1;
        rdata_d        = we_q ? '0 : BiSetReplyData(setReply_i);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction without an ack.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      gnt_q   <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign setCtrl_o = ctrl_q;
  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: doc/bi_set_arbiter.md
BI_SET_ARBITER -- requirements
Module: bi_set_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one BiSet bus (legal 2..16).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_i, input, N_REQ bits: per-requester transaction request, held until that requester's ack.
REQ-005 The block SHALL have port we_i, input, N_REQ bits: per-requester write enable (1 = write, 0 = read).
REQ-006 The block SHALL have port addr_i, input, N_REQ x BiSet::ADDR_W: per-requester target address.
REQ-007 The block SHALL have port wdata_i, input, N_REQ x BiSet::DATA_W: per-requester write data.
REQ-008 The block SHALL have port ack_o, output, N_REQ bits: one-cycle completion pulse, one-hot or zero.
REQ-009 The block SHALL have port rdata_o, output, BiSet::DATA_W: read result, valid in the ack_o cycle.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high while the FSM is not IDLE.
REQ-011 The block SHALL have port setCtrl_o, output, BiSet::biSetCtrl: the shared bus control towards all slaves.
REQ-012 The block SHALL have port setReply_i, input, BiSet::biSetReply: the OR-combined slave replies.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, ISSUE and CAPTURE, with transitions IDLE->ISSUE on any req_i bit, ISSUE->CAPTURE unconditionally, and CAPTURE->IDLE unconditionally.
REQ-014 In IDLE with req_i nonzero, the block SHALL grant round-robin: search starts at index (last_grant+1) mod N_REQ, wrapping; the granted index becomes last_grant.
REQ-015 On grant, the block SHALL latch the granted requester's we, addr and wdata; later changes on that requester's inputs SHALL NOT affect the transaction.
REQ-016 In ISSUE, setCtrl_o SHALL carry the latched addr, we and wdata for exactly one cycle; in every other state setCtrl_o SHALL be all-zero (write enable 0).
REQ-017 Slaves reply one cycle after the ctrl cycle, so in CAPTURE the block SHALL sample setReply_i: on a read, rdata_o <= BiSet::BiSetReplyData(setReply_i); on a write, rdata_o <= 0.
REQ-018 ack_o SHALL pulse high for exactly one cycle on the granted bit, in the cycle after CAPTURE (the IDLE cycle), registered alongside rdata_o.
REQ-019 Latency SHALL be fixed: req_i sampled in IDLE at cycle t, setCtrl_o at t+1, capture at t+2, ack_o/rdata_o at t+3.
REQ-020 The block SHALL mask the requester acked in the current cycle from arbitration in that cycle; a new grant may start at t+3 for any other requester and at t+4 for the same requester.
REQ-021 rdata_o SHALL hold its value until the next CAPTURE.
REQ-022 A read to an address no slave decodes SHALL return 0, as the OR of idle replies; no timeout exists.
REQ-023 Requests rising during ISSUE or CAPTURE SHALL wait and SHALL NOT be lost.
REQ-024 Throughput SHALL be one transaction per 3 cycles when requests are continuous.

Reset
REQ-025 When rst_ni is low at a clock edge, the block SHALL set: FSM to IDLE, last_grant to N_REQ-1 (requester 0 wins first), ack_o to 0, rdata_o to 0, busy_o to 0, and setCtrl_o to all-zero.
REQ-026 Reset mid-transaction SHALL abort the transaction without ack; an interrupted ISSUE SHALL NOT repeat after reset.

Structure
REQ-027 ADDR_W, DATA_W, biSetCtrl, biSetReply, BiSetCtrlPack(addr, we, data) and BiSetReplyData(reply) SHALL live in package BiSet; the block SHALL declare no bus types locally.
REQ-028 The round-robin search SHALL be a sub-module, bi_set_rr_pick (inputs: req vector, mask, last index; outputs: valid, index), purely combinational.

Verification
REQ-029 Single read: a read-0 BiSet slave at 0x10 returns 0xA5; req_i[2]=1, we=0, addr=0x10 -> one ctrl cycle at t+1, ack_o=0b0100 at t+3, rdata_o=0xA5.
REQ-030 Write: requester 1 writes 0x3C to 0x20 -> setCtrl_o shows we=1, addr 0x20, data 0x3C for exactly one cycle; ack_o=0b0010 at t+3; rdata_o=0.
REQ-031 Fairness: req_i=0b1111 held continuously after reset -> grants in order 0,1,2,3,0, with acks at 3-cycle spacing.
REQ-032 Masking: requester 3 keeps req high through its ack while requester 1 requests -> the next grant goes to 1, and 3 is served afterwards.
REQ-033 Reset: rst_ni low in the CAPTURE cycle -> no ack_o, setCtrl_o=0 and busy_o=0 the next cycle; with req_i=0b0001 after release, requester 0 is served with normal latency.
REQ-034 Unmapped read at 0x7F -> rdata_o=0 with ack at t+3.
